// File: rtl/class_vote_accumulator.sv
// Per-image class vote accumulator: counts per-class firing bits over all sliding windows,
// then scans the counters for the winning class and pulses result_valid once.
module class_vote_accumulator #(
  parameter int unsigned NUM_OUTPUT_CLASSES = 10,
  parameter int unsigned OUTPUT_DATA_WIDTH  = 10,
  parameter int unsigned NUM_WINDOWS        = 900,
  parameter int unsigned COUNT_WIDTH        = $clog2(NUM_WINDOWS + 1),
  parameter int unsigned CLASS_IDX_WIDTH    = $clog2(NUM_OUTPUT_CLASSES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         calc_valid,
  input  logic [OUTPUT_DATA_WIDTH-1:0] calc_output,
  output logic                         busy,
  output logic                         result_valid,
  output logic [CLASS_IDX_WIDTH-1:0]   result_class,
  output logic [COUNT_WIDTH-1:0]       result_count,
  output logic                         overrun
);

  typedef enum logic [1:0] {StIdle, StAccum, StArgmax, StDone} state_e;

  localparam logic [COUNT_WIDTH-1:0]     CountMax   = '1;
  localparam logic [COUNT_WIDTH-1:0]     LastWindow = COUNT_WIDTH'(NUM_WINDOWS - 1);
  localparam logic [CLASS_IDX_WIDTH-1:0] LastIdx    = CLASS_IDX_WIDTH'(NUM_OUTPUT_CLASSES - 1);

  state_e                     state_q, state_d;
  logic [COUNT_WIDTH-1:0]     count_q [NUM_OUTPUT_CLASSES];
  logic [COUNT_WIDTH-1:0]     count_d [NUM_OUTPUT_CLASSES];
  logic [COUNT_WIDTH-1:0]     window_cnt_q, window_cnt_d;
  logic [CLASS_IDX_WIDTH-1:0] scan_idx_q, scan_idx_d;
  logic [CLASS_IDX_WIDTH-1:0] best_class_q, best_class_d;
  logic [COUNT_WIDTH-1:0]     best_count_q, best_count_d;
  logic [CLASS_IDX_WIDTH-1:0] result_class_q, result_class_d;
  logic [COUNT_WIDTH-1:0]     result_count_q, result_count_d;
  logic                       result_valid_q, result_valid_d;
  logic                       overrun_q, overrun_d;
  // Set on entry to DONE; the result is published on the first DONE cycle.
  logic                       pending_q, pending_d;

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    window_cnt_d   = window_cnt_q;
    scan_idx_d     = scan_idx_q;
    best_class_d   = best_class_q;
    best_count_d   = best_count_q;
    result_class_d = result_class_q;
    result_count_d = result_count_q;
    result_valid_d = 1'b0;
    overrun_d      = overrun_q;
    pending_d      = pending_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          count_d        = '{default: '0};
          window_cnt_d   = '0;
          result_class_d = '0;
          result_count_d = '0;
          overrun_d      = 1'b0;
          pending_d      = 1'b0;
          state_d        = StAccum;
        end else begin
          if (calc_valid) overrun_d = 1'b1;
          if (pending_q) begin
            result_valid_d = 1'b1;
            result_class_d = best_class_q;
            result_count_d = best_count_q;
            pending_d      = 1'b0;
          end
        end
      end
      StAccum: begin
        if (calc_valid) begin
          for (int i = 0; i < NUM_OUTPUT_CLASSES; i++) begin
            if (calc_output[i] && (count_q[i] != CountMax)) count_d[i] = count_q[i] + 1'b1;
          end
          window_cnt_d = window_cnt_q + 1'b1;
          if (window_cnt_q == LastWindow) begin
            state_d      = StArgmax;
            scan_idx_d   = '0;
            best_class_d = '0;
            best_count_d = '0;
          end
        end
      end
      StArgmax: begin
        if (calc_valid) overrun_d = 1'b1;
        // Strict compare keeps the lowest index on ties.
        if (count_q[scan_idx_q] > best_count_q) begin
          best_class_d = scan_idx_q;
          best_count_d = count_q[scan_idx_q];
        end
        if (scan_idx_q == LastIdx) begin
          state_d   = StDone;
          pending_d = 1'b1;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      count_q        <= '{default: '0};
      window_cnt_q   <= '0;
      scan_idx_q     <= '0;
      best_class_q   <= '0;
      best_count_q   <= '0;
      result_class_q <= '0;
      result_count_q <= '0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      pending_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      window_cnt_q   <= window_cnt_d;
      scan_idx_q     <= scan_idx_d;
      best_class_q   <= best_class_d;
      best_count_q   <= best_count_d;
      result_class_q <= result_class_d;
      result_count_q <= result_count_d;
      result_valid_q <= result_valid_d;
      overrun_q      <= overrun_d;
      pending_q      <= pending_d;
    end
  end

  assign busy         = (state_q == StAccum) || (state_q == StArgmax);
  assign result_valid = result_valid_q;
  assign result_class = result_class_q;
  assign result_count = result_count_q;
  assign overrun      = overrun_q;

endmodule

// File: doc/class_vote_accumulator.md
Name: class_vote_accumulator

Overview:
- Sits directly downstream of the neural core.
- Consumes the per-window class vector (calcOutput) each time the core's done pulses, and keeps one vote counter per output class across all sliding windows of one image.
- After the last window, scans the counters sequentially, reports the winning class and its vote count, and issues a single-cycle result_valid pulse.

Parameters:
NUM_OUTPUT_CLASSES, 10, number of classes; must equal OUTPUT_DATA_WIDTH
OUTPUT_DATA_WIDTH, 10, width of calc_output
NUM_WINDOWS, 900, windows per image ((32-3)/1+1)^2
COUNT_WIDTH, $clog2(NUM_WINDOWS+1), vote counter width
CLASS_IDX_WIDTH, $clog2(NUM_OUTPUT_CLASSES), class index width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin a new image; accepted only in IDLE or DONE
calc_valid  input  1  one-cycle pulse per window result (driven by the core's done)
calc_output  input  OUTPUT_DATA_WIDTH  per-class firing bits for the window
busy  output  1  high in ACCUM and ARGMAX
result_valid  output  1  one-cycle pulse when the result is ready
result_class  output  CLASS_IDX_WIDTH  winning class index, held until the next accepted start
result_count  output  COUNT_WIDTH  vote count of the winning class, held likewise
overrun  output  1  sticky flag: calc_valid arrived outside ACCUM; cleared by an accepted start or rst

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; all counters, window_cnt, scan index and best registers cleared to 0; all outputs 0. Reset mid-operation aborts immediately; no result_valid is produced.
- States: IDLE, ACCUM, ARGMAX, DONE.
- IDLE/DONE + start:
  - clear all class counters, window_cnt, result_class, result_count and overrun;
  - go to ACCUM.
  - A calc_valid in the same cycle is ignored and does not set overrun.
- start in ACCUM or ARGMAX: ignored; it does not restart the image.
- ACCUM, on each calc_valid:
  - for every i with calc_output[i]=1, count[i] increments by 1, saturating at 2^COUNT_WIDTH-1;
  - window_cnt increments by 1.
  - On the calc_valid that makes window_cnt reach NUM_WINDOWS: go to ARGMAX with scan index 0, best_class 0, best_count 0.
  - calc_valid may have arbitrary gaps; cycles without calc_valid change nothing.
- ARGMAX: one class per cycle, index 0 to NUM_OUTPUT_CLASSES-1.
  - If count[idx] > best_count (strict), then best_class=idx and best_count=count[idx]. Ties therefore go to the lowest index.
  - After index NUM_OUTPUT_CLASSES-1 is evaluated: go to DONE.
- DONE, first cycle:
  - result_valid=1 for exactly one cycle;
  - result_class and result_count are loaded from the best registers;
  - then stay in DONE (busy=0) until start.
- Latency: final calc_valid sampled at edge t; result_valid is high in the cycle after edge t+NUM_OUTPUT_CLASSES+1 (11 cycles for defaults); results valid in that same cycle.
- All-zero votes: result_class=0, result_count=0.
- calc_valid in IDLE, ARGMAX or DONE (except alongside an accepted start): counters untouched; overrun set to 1.
- busy=1 exactly in ACCUM and ARGMAX.

Test Plan:
1. Hold rst 2 cycles mid-ACCUM (after 3 windows) -> busy=0, result_valid=0, result_class=0, result_count=0, overrun=0; a subsequent start plus 4 windows gives a fresh result unaffected by the aborted votes.
2. NUM_WINDOWS=4; start; calc_output=0x004, 0x004, 0x00C, 0x001 with gaps of 0-3 cycles -> result_valid pulses once, 11 cycles after the last valid edge; result_class=2, result_count=3.
3. NUM_WINDOWS=4; four windows of 0x201 -> tie between classes 0 and 9 at 4 votes; result_class=0, result_count=4.
4. NUM_WINDOWS=4; four windows of 0x000 -> result_class=0, result_count=0, result_valid pulses once.
5. Default parameters; 900 windows of 0x3FF except class 7 set in only 899 of them -> result_class=0, result_count=900; busy low after DONE; start while busy is ignored and does not shorten the run.
6. NUM_WINDOWS=4; inject calc_valid=1 with 0x3FF during ARGMAX -> counts unchanged, result unchanged, overrun=1 and held; next start clears overrun to 0.
